// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS32 pipeline stages.
//   - load_size_e : encodings for the load size field (byte/half/word/reserved)
//   - REG_W       : register-index width
//   - DATA_W      : default datapath width
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } load_size_e;

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational sub-word load alignment and extension.
// Ports:
//   word    - raw load data (WIDTH bits); lanes taken from the low 32 bits
//   size    - load size (byte / half / word / reserved)
//   sgn     - sign-extend sub-word results when 1, zero-extend when 0
//   addr_lo - low two effective-address bits selecting the lane
//   aligned - aligned and extended result
module wb_load_align
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       size,
  input  logic             sgn,
  input  logic [1:0]       addr_lo,
  output logic [WIDTH-1:0] aligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    // Halfword lane pair is chosen by addr_lo[1] only; addr_lo[0] is ignored.
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    aligned = word;
    case (load_size_e'(size))
      SZ_BYTE: aligned = {{(WIDTH-8){sgn & byte_lane[7]}}, byte_lane};
      SZ_HALF: aligned = {{(WIDTH-16){sgn & half_lane[15]}}, half_lane};
      default: aligned = word;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: MEM->WB stage. Selects one of NUM_SRC data sources,
// aligns sub-word loads on LOAD_SRC, and holds results in a 2-entry
// in-order skid buffer feeding the register-file write port.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid / in_ready      - upstream handshake
//   in_sel, in_data          - source select and packed sources
//   in_rd, in_regwrite       - destination register and write request
//   in_size, in_signed,
//   in_addr_lo               - load alignment controls
//   flush                    - drop buffered and incoming entries
//   out_valid / out_ready    - write-back handshake
//   out_data, out_rd,
//   out_regwrite             - head entry contents
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds its payload stable while valid && !ready; ready never
// depends combinationally on the partner's valid (in_ready depends only on
// the registered occupancy and rst).
module wb_select_stage
  import mips_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int NUM_SRC  = 4,
  parameter int LOAD_SRC = 1,
  parameter int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [REG_W-1:0]         in_rd,
  input  logic                     in_regwrite,
  input  logic [1:0]               in_size,
  input  logic                     in_signed,
  input  logic [1:0]               in_addr_lo,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [REG_W-1:0]         out_rd,
  output logic                     out_regwrite
);

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] aligned_word;
  logic [WIDTH-1:0] new_data;
  logic             new_rw;
  logic             sel_ok;
  logic             push;
  logic             pop;

  logic [1:0]       count;
  logic [WIDTH-1:0] head_data;
  reg_idx_t         head_rd;
  logic             head_rw;
  logic [WIDTH-1:0] tail_data;
  reg_idx_t         tail_rd;
  logic             tail_rw;

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  wb_load_align #(.WIDTH(WIDTH)) u_align (
    .word    (sel_word),
    .size    (in_size),
    .sgn     (in_signed),
    .addr_lo (in_addr_lo),
    .aligned (aligned_word)
  );

  // Out-of-range selects produce a harmless no-op entry (data 0, no write).
  assign sel_ok   = int'(in_sel) < NUM_SRC;
  assign new_data = !sel_ok ? '0 :
                    (in_sel == SEL_W'(LOAD_SRC)) ? aligned_word : sel_word;
  assign new_rw   = in_regwrite && sel_ok && (in_rd != '0);

  assign in_ready     = (count != 2'd2) && !rst;
  assign out_valid    = (count != 2'd0);
  assign out_data     = head_data;
  assign out_rd       = head_rd;
  assign out_regwrite = head_rw && out_valid;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Head registers only change when empty or on a pop, so the head stays
  // stable under backpressure and keeps its last value when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head_data <= '0;
      head_rd   <= '0;
      head_rw   <= 1'b0;
      tail_data <= '0;
      tail_rd   <= '0;
      tail_rw   <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data <= new_data;
            head_rd   <= in_rd;
            head_rw   <= new_rw;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= new_data;
            head_rd   <= in_rd;
            head_rw   <= new_rw;
          end else if (push) begin
            tail_data <= new_data;
            tail_rd   <= in_rd;
            tail_rw   <= new_rw;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_data <= tail_data;
            head_rd   <= tail_rd;
            head_rw   <= tail_rw;
            count     <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;
  localparam int WIDTH = 32;
  localparam int NUM_SRC = 3;
  localparam int LOAD_SRC = 1;
  localparam int SEL_W = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_SRC*WIDTH-1:0] in_data;
  logic [4:0]               in_rd;
  logic                     in_regwrite;
  logic [1:0]               in_size;
  logic                     in_signed;
  logic [1:0]               in_addr_lo;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [4:0]               out_rd;
  logic                     out_regwrite;

  int total = 0;
  int bad = 0;

  wb_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .LOAD_SRC(LOAD_SRC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_size(in_size), .in_signed(in_signed), .in_addr_lo(in_addr_lo),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_regwrite(out_regwrite)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel,
                       input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] rd, input logic rw, input logic [1:0] sz,
                       input logic sg, input logic [1:0] al);
    in_valid    = v;
    in_sel      = sel;
    in_data     = {s2, s1, s0};
    in_rd       = rd;
    in_regwrite = rw;
    in_size     = sz;
    in_signed   = sg;
    in_addr_lo  = al;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b10, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_rd !== 5'd0) begin bad++; $display("FAIL reset_out_rd got=%0d exp=0", out_rd); end
    total++; if (out_regwrite !== 1'b0) begin bad++; $display("FAIL reset_out_regwrite got=%b exp=0", out_regwrite); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd5, 1'b1, 2'b10, 1'b0, 2'd0);
    step();
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h1234_5678) begin bad++; $display("FAIL basic_data got=%h exp=12345678", out_data); end
    total++; if (out_rd !== 5'd5) begin bad++; $display("FAIL basic_rd got=%0d exp=5", out_rd); end
    total++; if (out_regwrite !== 1'b1) begin bad++; $display("FAIL basic_regwrite got=%b exp=1", out_regwrite); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b exp=0", out_valid); end
    total++; if (out_regwrite !== 1'b0) begin bad++; $display("FAIL basic_rw_gated got=%b exp=0", out_regwrite); end
    total++; if (out_data !== 32'h1234_5678) begin bad++; $display("FAIL basic_data_hold got=%h exp=12345678", out_data); end
  endtask

  task automatic test_load_align();
    logic [1:0]  t_sel [0:7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
    logic [1:0]  t_sz  [0:7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
    logic        t_sg  [0:7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  t_al  [0:7] = '{2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2};
    logic [31:0] t_exp [0:7] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF,
                                 32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_007F, 32'h0000_80FF};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t_sel[i], 32'h80FF_7F01, 32'h80FF_7F01, 32'h0, 5'd3, 1'b1, t_sz[i], t_sg[i], t_al[i]);
      step();
      idle();
      total++; if (out_valid !== 1'b1 || out_data !== t_exp[i]) begin
        bad++; $display("FAIL load_%0d got valid=%b data=%h exp valid=1 data=%h", i, out_valid, out_data, t_exp[i]);
      end
      step();
    end
  endtask

  task automatic test_qualify();
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    step(); idle();
    total++; if (out_valid !== 1'b1 || out_regwrite !== 1'b0) begin
      bad++; $display("FAIL rd0_regwrite got valid=%b rw=%b exp valid=1 rw=0", out_valid, out_regwrite); end
    step();
    drive(1'b1, 2'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd7, 1'b1, 2'b10, 1'b0, 2'd0);
    step(); idle();
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL oor_data got=%h exp=0", out_data); end
    total++; if (out_regwrite !== 1'b0) begin bad++; $display("FAIL oor_regwrite got=%b exp=0", out_regwrite); end
    total++; if (out_rd !== 5'd7) begin bad++; $display("FAIL oor_rd got=%0d exp=7", out_rd); end
    step();
    drive(1'b1, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'hCAFE_F00D, 5'd9, 1'b1, 2'b00, 1'b1, 2'd3);
    step(); idle();
    total++; if (out_data !== 32'hCAFE_F00D || out_regwrite !== 1'b1) begin
      bad++; $display("FAIL src2 got data=%h rw=%b exp data=cafef00d rw=1", out_data, out_regwrite); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'hA0A0_0001, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 1'b0, 2'd0);
    step();
    total++; if (out_data !== 32'hA0A0_0001 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_first got data=%h rdy=%b exp data=a0a00001 rdy=1", out_data, in_ready); end
    drive(1'b1, 2'd0, 32'hA0A0_0002, 32'h0, 32'h0, 5'd2, 1'b0, 2'b10, 1'b0, 2'd0);
    step();
    drive(1'b1, 2'd0, 32'hA0A0_0003, 32'h0, 32'h0, 5'd3, 1'b1, 2'b10, 1'b0, 2'd0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got rdy=%b exp=0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (out_data !== 32'hA0A0_0001 || out_rd !== 5'd1 || out_regwrite !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_stable_%0d got data=%h rd=%0d rw=%b rdy=%b", i, out_data, out_rd, out_regwrite, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_no_comb_ready got=%b exp=0", in_ready); end
    step();
    total++; if (out_data !== 32'hA0A0_0002 || out_rd !== 5'd2 || out_regwrite !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_second got data=%h rd=%0d rw=%b rdy=%b", out_data, out_rd, out_regwrite, in_ready); end
    step();
    idle();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA0A0_0003 || out_rd !== 5'd3) begin
      bad++; $display("FAIL bp_third got valid=%b data=%h rd=%0d", out_valid, out_data, out_rd); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 32'hB000_0000 + i, 32'h0, 32'h0, 5'(i + 1), i[0], 2'b10, 1'b0, 2'd0);
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 32'hB000_0000 + i || out_rd !== 5'(i + 1) ||
                   out_regwrite !== i[0] || in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got valid=%b data=%h rd=%0d rw=%b rdy=%b", i, out_valid, out_data, out_rd, out_regwrite, in_ready);
      end
    end
    idle();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h1111_1111, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, 1'b0, 2'd0);
    step();
    drive(1'b1, 2'd0, 32'h2222_2222, 32'h0, 32'h0, 5'd2, 1'b1, 2'b10, 1'b0, 2'd0);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full got=%b exp=0", in_ready); end
    drive(1'b1, 2'd0, 32'h3333_3333, 32'h0, 32'h0, 5'd3, 1'b1, 2'b10, 1'b0, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_regwrite !== 1'b0) begin
      bad++; $display("FAIL flush_full got valid=%b rdy=%b rw=%b exp 0/1/0", out_valid, in_ready, out_regwrite); end
    // Flush with one entry held and a push that would otherwise be accepted.
    drive(1'b1, 2'd0, 32'h4444_4444, 32'h0, 32'h0, 5'd4, 1'b1, 2'b10, 1'b0, 2'd0);
    step();
    drive(1'b1, 2'd0, 32'h5555_5555, 32'h0, 32'h0, 5'd5, 1'b1, 2'b10, 1'b0, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale_%0d got valid=%b data=%h exp valid=0", i, out_valid, out_data); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 5'd7, 1'b1, 2'b10, 1'b0, 2'd0);
    step();
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_regwrite !== 1'b0 || out_data !== 32'h0) begin
      bad++; $display("FAIL rstmid_async got valid=%b rdy=%b rw=%b data=%h", out_valid, in_ready, out_regwrite, out_data); end
    step();
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_release got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale_%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_align();
    test_qualify();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised MEM→WB stage of the MIPS32 pipeline, successor to the two-input memory-stage data mux. Each cycle it accepts one instruction result over a valid/ready handshake. It selects one of `NUM_SRC` candidate data sources; examples are the ALU result, load data, and the link address. It aligns and extends sub-word loads, then buffers the result with its destination register in a 2-entry in-order skid buffer that feeds the register-file write port.

## Interface
Parameters:
- `WIDTH`, 32, datapath width in bits (multiple of 16).
- `NUM_SRC`, 4, number of selectable data sources (≥2).
- `LOAD_SRC`, 1, source index that carries raw load data and receives alignment.
- `SEL_W`, `$clog2(NUM_SRC)`, derived; not overridden.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `in_valid` in 1 — upstream offers an instruction.
- `in_ready` out 1 — stage can accept.
- `in_sel` in `SEL_W` — source select.
- `in_data` in `NUM_SRC*WIDTH` — packed sources; source k occupies `[k*WIDTH +: WIDTH]`.
- `in_rd` in 5 — destination register.
- `in_regwrite` in 1 — instruction writes `in_rd`.
- `in_size` in 2 — load size: 00 byte, 01 half, 10 word, 11 reserved.
- `in_signed` in 1 — sign-extend sub-word load.
- `in_addr_lo` in 2 — low effective-address bits of the load.
- `flush` in 1 — discard all buffered and incoming entries.
- `out_valid` out 1 — head entry valid.
- `out_ready` in 1 — write-back consumes head.
- `out_data` out `WIDTH` — head data.
- `out_rd` out 5 — head destination.
- `out_regwrite` out 1 — head write enable. Already qualified; never 1 when `out_valid` is 0.

## Operation
- Transfers: input on `in_valid && in_ready`; output on `out_valid && out_ready`.
- Select:
  - `sel < NUM_SRC`: chosen word is source `sel`.
  - `sel ≥ NUM_SRC`: data is 0 and regwrite is forced to 0.
- Load alignment applies only when `sel == LOAD_SRC`. Byte lanes are little-endian: byte k = `[8k+7:8k]`.
  - Byte: lane `addr_lo`.
  - Half: lane pair `addr_lo[1]`; `addr_lo[0]` is ignored.
  - Word or reserved size: unchanged.
  - Sub-word results are zero-extended, or sign-extended when `in_signed`, to `WIDTH`.
  - For `WIDTH > 32`, lanes index the low 32 bits.
- Regwrite is forced to 0 when `in_rd == 0`.
- Buffer: 2 entries, FIFO order, occupancy count 0..2.
  - `in_ready = (count < 2) && !rst`.
  - count 1 with push and pop in the same cycle: count stays 1, and the new entry becomes head next cycle.
  - count 2 with pop: count becomes 1, and `in_ready` rises the following cycle. It does not rise combinationally from `out_ready`.
- `flush`: on that edge, count becomes 0 and any incoming transfer is discarded. Flush overrides push and pop.
- Reset: count 0. `out_valid`, `out_data`, `out_rd` and `out_regwrite` are all 0, and `in_ready` is 0 while `rst` is high. Reset mid-stream drops all entries.
- While `out_valid` is 0, `out_data` and `out_rd` hold their last values. They are zero after reset.

## Timing
- Latency: an entry accepted at edge N into an empty buffer has `out_valid` = 1 after edge N. No combinational path runs from `in_*` to `out_*`.
- Throughput is 1/cycle while `out_ready` is held high.
- All outputs are registered, except `out_regwrite` gating (`entry_rw && out_valid`).
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_rd` and `out_regwrite` must not change.

## Structure
- Shared package `mips_pkg` holds:
  - load-size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - register-index width `REG_W` = 5;
  - default `WIDTH` = 32.
- Sub-module `wb_load_align` (combinational): word, size, signed and addr_lo in; aligned and extended word out.
- The select, qualification and buffer logic lives in the top module.

## Test plan
- After reset, sel=0, src0=`32'h1234_5678`, rd=5, regwrite=1, out_ready=1 → next cycle `out_data`=`32'h1234_5678`, rd=5, `out_regwrite`=1.
- LOAD_SRC word `32'h80FF_7F01`:
  - byte, signed, addr_lo=2 → `32'hFFFF_FFFF`;
  - byte, unsigned, addr_lo=3 → `32'h0000_0080`;
  - half, signed, addr_lo=0 → `32'h0000_7F01`.
- Backpressure: out_ready=0 while 3 back-to-back inputs are offered.
  - First two are accepted and `in_ready` drops.
  - Head stays stable.
  - Raising out_ready drains the entries in order, then the third is accepted.
- rd=0 with regwrite=1 → `out_regwrite`=0. sel=`NUM_SRC` (parameter override `NUM_SRC`=3) → data 0 and `out_regwrite`=0.
- Flush with count=2 and in_valid=1 → next cycle out_valid=0 and count=0, and the incoming entry never appears.
- Assert rst mid-stream with 1 entry held → `out_valid` and `in_ready` are immediately 0. After release, `in_ready`=1 and no stale entry emerges.
